nbbpu_sequencer: RTL and testbench

- Multi-cycle control sequencer for the NBBPU core. It steps each instruction through fetch, decode, execute/memory and write-back phases.
- Sits between the instruction decoder/controller and the shared single-port memory. It owns the memory request handshake, the instruction-register load, the PC update and the register-file write strobe.
- Detects HALT opcodes and memory time-outs.
- Keeps a retired-instruction counter for debug.

---
 rtl/nbbpu_sequencer.sv | 151 +++++++++++++++
 tb/tb_nbbpu_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/nbbpu_sequencer.sv
// Multi-cycle control sequencer for the NBBPU core: steps each instruction
// through fetch, decode, execute/memory and write-back, owns the memory
// handshake, and flags HALT opcodes and memory time-outs.
module nbbpu_sequencer #(
  parameter logic [3:0]  OP_LOAD    = 4'b1100,
  parameter logic [3:0]  OP_STORE   = 4'b1101,
  parameter logic [3:0]  OP_HALT    = 4'b1111,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [3:0]  opcode,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_select,
  output logic        instr_load,
  output logic        PC_enable,
  output logic        reg_write_enable,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state,
  output logic [15:0] retired
);

  localparam int unsigned WAIT_W = 8;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd6;
  localparam logic [2:0] S_FAULT     = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [3:0]        op_q, op_d;
  logic [15:0]       retired_q, retired_d;

  // State, wait counter, latched opcode and retire counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, wait-counter and retire-counter logic
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    op_d      = op_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_q == WAIT_W'(WAIT_LIMIT)) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        // Opcode is captured here so later phases ignore IR changes
        op_d = opcode;
        if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
          state_d = S_MEMORY;
          wait_d  = '0;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE, S_WRITEBACK: begin
        retired_d = retired_q + 16'd1;
        wait_d    = '0;
        state_d   = run ? S_FETCH : S_IDLE;
      end
      S_MEMORY: begin
        if (mem_ready) begin
          state_d = S_WRITEBACK;
        end else if (wait_q == WAIT_W'(WAIT_LIMIT)) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // Outputs decoded from registered state; instr_load also follows mem_ready
  always_comb begin
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    mem_select       = 1'b0;
    instr_load       = 1'b0;
    PC_enable        = 1'b0;
    reg_write_enable = 1'b0;
    halted           = 1'b0;
    fault            = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        instr_load = mem_ready;
      end
      S_EXECUTE: begin
        reg_write_enable = 1'b1;
        PC_enable        = 1'b1;
      end
      S_MEMORY: begin
        mem_select = 1'b1;
        mem_read   = (op_q == OP_LOAD);
        mem_write  = (op_q == OP_STORE);
      end
      S_WRITEBACK: begin
        PC_enable        = 1'b1;
        reg_write_enable = (op_q == OP_LOAD);
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: begin
        mem_read = 1'b0;
      end
    endcase
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_nbbpu_sequencer.sv
// Directed testbench for nbbpu_sequencer.
module tb_nbbpu_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [3:0]  opcode = 4'b0000;
  logic        mem_ready = 1'b1;
  logic        mem_read, mem_write, mem_select, instr_load;
  logic        PC_enable, reg_write_enable, halted, fault;
  logic [2:0]  state;
  logic [15:0] retired;

  int errors = 0;
  int checks = 0;

  nbbpu_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .run              (run),
    .opcode           (opcode),
    .mem_ready        (mem_ready),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_select       (mem_select),
    .instr_load       (instr_load),
    .PC_enable        (PC_enable),
    .reg_write_enable (reg_write_enable),
    .halted           (halted),
    .fault            (fault),
    .state            (state),
    .retired          (retired)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0] seq [3];
    logic [2:0] exp_st;
    seq[0] = 3'd1; seq[1] = 3'd2; seq[2] = 3'd3;

    // Reset values
    step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_strobes", 32'({mem_read, mem_write, mem_select, instr_load,
                            PC_enable, reg_write_enable, halted, fault}), 32'd0);
    reset = 1'b0;
    run   = 1'b1;

    // ALU stream with memory always ready
    step();
    chk("alu_fetch", 32'(state), 32'd1);
    chk("alu_ild", 32'(instr_load), 32'd1);
    for (int i = 1; i <= 9; i++) begin
      step();
      exp_st = seq[i % 3];
      chk("alu_state", 32'(state), 32'(exp_st));
      chk("alu_pcen", 32'(PC_enable), 32'(exp_st == 3'd3));
    end
    chk("alu_retired", 32'(retired), 32'd3);

    // Load with two not-ready cycles in MEMORY
    opcode = 4'b1100;
    step();
    chk("ld_decode", 32'(state), 32'd2);
    mem_ready = 1'b0;
    step();
    chk("ld_mem1", 32'({state, mem_read, mem_select, mem_write}), 32'({3'd4, 3'b110}));
    step();
    chk("ld_mem2", 32'({state, mem_read, mem_select, mem_write}), 32'({3'd4, 3'b110}));
    mem_ready = 1'b1;
    opcode    = 4'b0000;
    #1;
    chk("ld_mem3", 32'({state, mem_read, mem_select, mem_write}), 32'({3'd4, 3'b110}));
    step();
    chk("ld_wb", 32'({state, reg_write_enable, PC_enable, mem_read}), 32'({3'd5, 3'b110}));
    step();
    chk("ld_retired", 32'(retired), 32'd4);
    chk("ld_refetch", 32'(state), 32'd1);

    // Store
    opcode = 4'b1101;
    step();
    chk("st_decode", 32'(state), 32'd2);
    step();
    opcode = 4'b0000;
    #1;
    chk("st_mem", 32'({state, mem_write, mem_read, mem_select}), 32'({3'd4, 3'b101}));
    step();
    chk("st_wb", 32'({state, reg_write_enable, PC_enable}), 32'({3'd5, 2'b01}));
    step();
    chk("st_retired", 32'(retired), 32'd5);

    // Reset mid-MEMORY during a store
    opcode = 4'b1101;
    step();
    step();
    mem_ready = 1'b0;
    #1;
    chk("rm_mem_write", 32'({state, mem_write}), 32'({3'd4, 1'b1}));
    #2;
    reset = 1'b1;
    #1;
    chk("rm_async", 32'({state, mem_write}), 32'd0);
    chk("rm_retired", 32'(retired), 32'd0);
    run = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rm_idle", 32'(state), 32'd0);
    end

    // HALT after two ALU instructions
    opcode    = 4'b0000;
    mem_ready = 1'b1;
    run       = 1'b1;
    step();
    for (int i = 0; i < 6; i++) step();
    chk("h_fetch", 32'(state), 32'd1);
    opcode = 4'b1111;
    step();
    step();
    chk("h_state", 32'({state, halted}), 32'({3'd6, 1'b1}));
    chk("h_retired", 32'(retired), 32'd2);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("h_hold", 32'({state, halted, PC_enable}), 32'({3'd6, 2'b10}));
    end
    chk("h_retired_hold", 32'(retired), 32'd2);

    // Fetch time-out
    opcode    = 4'b0000;
    mem_ready = 1'b0;
    do_reset();
    step();
    chk("to_fetch", 32'(state), 32'd1);
    for (int i = 2; i <= 16; i++) begin
      step();
      chk("to_wait", 32'({state, fault}), 32'({3'd1, 1'b0}));
    end
    step();
    chk("to_fault", 32'({state, fault}), 32'({3'd7, 1'b1}));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_absorb", 32'(state), 32'd7);
    end

    // Ready on the last allowed cycle is accepted
    do_reset();
    step();
    for (int i = 2; i <= 16; i++) step();
    chk("lim_c16", 32'(state), 32'd1);
    mem_ready = 1'b1;
    #1;
    chk("lim_ild", 32'(instr_load), 32'd1);
    step();
    chk("lim_decode", 32'({state, fault}), 32'({3'd2, 1'b0}));
    step();
    chk("lim_exec", 32'(state), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
